alu_writeback: RTL
==================

Name: alu_writeback

Overview:
- Downstream stage of the 16-bit ALU: a 2-entry write queue drains ALU results into an 8x16 register file and ALU flags into a 4-bit status register.
- The register file's two combinational read ports supply the ALU's `a` and `b` operands, closing the datapath loop.
- Read-after-write hazards against queued results are reported to the sequencer. With forwarding enabled, they are also resolved by bypassing the queue.

Parameters:
- WIDTH, 16, data width of results and registers
- NREGS, 8, number of architectural registers
- AW, 3, register address width (log2 of NREGS)
- DEPTH, 2, write-queue entries (fixed at 2; other values unsupported)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result presented
- in_ready  out  1  queue can accept an entry this cycle
- in_dest  in  AW  destination register index
- in_result  in  WIDTH  ALU result
- in_sreg  in  4  ALU status flags, stored opaquely, bit order unchanged
- in_sreg_we  in  1  entry updates the status register when committed
- commit_en  in  1  permit head entry to retire this cycle (writeback stall when 0)
- ra_addr  in  AW  read port A address (feeds ALU a)
- rb_addr  in  AW  read port B address (feeds ALU b)
- ra_data  out  WIDTH  read port A data
- rb_data  out  WIDTH  read port B data
- ra_hazard  out  1  ra_addr matches the dest of a queued, uncommitted entry
- rb_hazard  out  1  rb_addr matches the dest of a queued, uncommitted entry
- sreg_q  out  4  committed status register
- count  out  2  queued entries, 0..2

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers = 0, sreg_q = 0, count = 0, queue valid bits cleared.
  - in_ready = 1 and hazards = 0 as soon as reset asserts.
  - Reset mid-operation discards queued entries without committing them.
- Push: on a rising edge with in_valid && in_ready, the entry {dest, result, sreg, sreg_we} enters the tail.
- in_ready = (count < 2), decoded from registered count only. When count == 2, in_ready = 0 even if a pop occurs in the same cycle (no full-queue pass-through).
- Pop: on a rising edge with commit_en && count > 0:
  - rf[head.dest] <= head.result;
  - if head.sreg_we, sreg_q <= head.sreg; otherwise sreg_q holds.
- Simultaneous push and pop with count == 1: count stays 1, the new entry becomes head, and the old head commits.
- Commit order is strictly FIFO.
- Latency: push at edge k from empty, with commit_en high, commits at edge k+1. The value is visible on ra_data/rb_data (no forwarding) from edge k+1 onward.
- commit_en = 0 holds the queue indefinitely, with no loss and no reordering.
- Read ports are combinational from the register file; ra_addr == rb_addr is legal.
- Hazards are combinational: asserted when the address equals the dest of any valid queued entry. They are independent of the forwarding option.
- Two queued entries with the same dest are legal; they commit in order, so the younger value wins.
- All arithmetic on count is 2-bit with no wrap; overflow is impossible because of the in_ready gating.

Optional Feature:
- Macro: ALU_WRITEBACK_FORWARD_EN.
- Defined:
  - ra_data/rb_data return in_result of the youngest valid queued entry whose dest matches, otherwise the register file.
  - Forwarding never uses the in_* bus of the current cycle.
- Undefined:
  - read ports return register file contents only.
  - The sequencer must stall on ra_hazard/rb_hazard.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with 2 queued entries -> immediately count=0, in_ready=1, sreg_q=0; after release, ra_addr=3 reads 0 and no stale commit ever occurs.
- Single write: push dest=2, result=17, sreg=4'b0000, sreg_we=1, commit_en=1 -> at next edge rf[2]=17 and sreg_q=0000; rb_addr=2 reads 17 afterwards.
- Stall and full:
  - commit_en=0; push dest=1 result=65535, then dest=4 result=0 with sreg=4'b0001 -> count=2, in_ready=0, ra_hazard=1 for ra_addr=1 and 4.
  - Third in_valid is not accepted.
  - Raise commit_en -> commits in order over 2 cycles, sreg_q=0001 after the second.
- Same dest, in order: queue dest=5 result=7 then dest=5 result=0 -> after drain, rf[5]=0.
  - Forward: with the macro defined, ra_addr=5 reads 0 while both entries are queued.
  - No forward: without the macro, ra_addr=5 reads the old rf value.
- Flag gating: commit result=1 with sreg_we=0 and sreg=4'b1111 after sreg_q=0010 -> sreg_q stays 0010.
- Simultaneous push and pop at count=1 -> count remains 1, old head committed, in_ready=1 throughout.

Source files
------------

// File: rtl/alu_writeback.sv
// ALU writeback stage: 2-entry write queue draining into an 8x16 register file and a 4-bit status register.
// Optional define ALU_WRITEBACK_FORWARD_EN lets the read ports bypass queued, uncommitted results.
module alu_writeback #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_dest,
  input  logic [WIDTH-1:0] in_result,
  input  logic [3:0]       in_sreg,
  input  logic             in_sreg_we,
  input  logic             commit_en,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  output logic             ra_hazard,
  output logic             rb_hazard,
  output logic [3:0]       sreg_q,
  output logic [1:0]       count
);

  typedef struct packed {
    logic [AW-1:0]    dest;
    logic [WIDTH-1:0] result;
    logic [3:0]       sreg;
    logic             sreg_we;
  } entry_t;

  // q[0] is always the head (oldest); q[1] is only meaningful when two entries are queued.
  entry_t           q [2];
  entry_t           in_entry;
  logic [1:0]       count_q;
  logic [WIDTH-1:0] rf [NREGS];
  logic             v0;
  logic             v1;
  logic             push;
  logic             pop;

  assign count = count_q;
  assign v0    = (count_q != 2'd0);
  assign v1    = (count_q == 2'd2);

  // Handshake: an entry transfers on a rising edge where in_valid && in_ready.
  // in_ready depends on the registered count only, so a full queue refuses even while popping.
  assign in_ready = (count_q != 2'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = commit_en && v0;

  assign in_entry = '{dest: in_dest, result: in_result, sreg: in_sreg, sreg_we: in_sreg_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      q[0]    <= '0;
      q[1]    <= '0;
    end else begin
      if (pop && v1) q[0] <= q[1];
      // With one entry, a concurrent pop frees the head slot for the new entry.
      if (push) begin
        if (v0 && !pop) q[1] <= in_entry;
        else            q[0] <= in_entry;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      sreg_q <= 4'd0;
    end else if (pop) begin
      rf[q[0].dest] <= q[0].result;
      if (q[0].sreg_we) sreg_q <= q[0].sreg;
    end
  end

  assign ra_hazard = (v0 && (q[0].dest == ra_addr)) || (v1 && (q[1].dest == ra_addr));
  assign rb_hazard = (v0 && (q[0].dest == rb_addr)) || (v1 && (q[1].dest == rb_addr));

`ifdef ALU_WRITEBACK_FORWARD_EN
  // Youngest matching queued entry wins; the in_* bus is never forwarded.
  always_comb begin
    ra_data = rf[ra_addr];
    if (v1 && (q[1].dest == ra_addr))      ra_data = q[1].result;
    else if (v0 && (q[0].dest == ra_addr)) ra_data = q[0].result;
  end

  always_comb begin
    rb_data = rf[rb_addr];
    if (v1 && (q[1].dest == rb_addr))      rb_data = q[1].result;
    else if (v0 && (q[0].dest == rb_addr)) rb_data = q[0].result;
  end
`else
  assign ra_data = rf[ra_addr];
  assign rb_data = rf[rb_addr];
`endif

endmodule
